// File: rtl/general_register_writeback_buffer_if.sv
// Handshake, drain and lookup bundle between the writeback buffer and its
// producers / register file. "slave" is the buffer side, "master" the user side.
interface general_register_writeback_buffer_if #(
    parameter int ADDRESS_WIDTH = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
);
    logic                       request_valid;
    logic                       request_ready;
    logic [ADDRESS_WIDTH-1:0]   request_address;
    logic [DATA_WIDTH-1:0]      request_data;
    logic                       write_inhibit;
    logic                       general_register_write_enable;
    logic [ADDRESS_WIDTH-1:0]   address_3;
    logic [DATA_WIDTH-1:0]      general_register_write_data;
    logic [ADDRESS_WIDTH-1:0]   lookup_address;
    logic                       lookup_hit;
    logic [DATA_WIDTH-1:0]      lookup_data;
    logic [$clog2(DEPTH):0]     occupancy;

    modport master (
        output request_valid, request_address, request_data, write_inhibit, lookup_address,
        input  request_ready, general_register_write_enable, address_3,
               general_register_write_data, lookup_hit, lookup_data, occupancy
    );

    modport slave (
        input  request_valid, request_address, request_data, write_inhibit, lookup_address,
        output request_ready, general_register_write_enable, address_3,
               general_register_write_data, lookup_hit, lookup_data, occupancy
    );
endinterface

// File: rtl/general_register_writeback_buffer.sv
// In-order writeback FIFO in front of the register file write port, with read bypass.
// Optional macro WRITEBACK_ZERO_REGISTER_DISCARD_EN: requests to register 0 are accepted and dropped.
module general_register_writeback_buffer #(
    parameter int ADDRESS_WIDTH = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input logic                            clk,
    input logic                            reset,
    general_register_writeback_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef WRITEBACK_ZERO_REGISTER_DISCARD_EN
    localparam bit DISCARD_ZERO = 1'b1;
`else
    localparam bit DISCARD_ZERO = 1'b0;
`endif

    logic [ADDRESS_WIDTH-1:0] entry_address [DEPTH];
    logic [DATA_WIDTH-1:0]    entry_data    [DEPTH];
    logic [DEPTH-1:0]         entry_valid;
    logic [PTR_W-1:0]         read_ptr;
    logic [PTR_W-1:0]         write_ptr;
    logic [CNT_W-1:0]         occupancy_count;

    logic full;
    logic empty;
    logic accept;
    logic enqueue;
    logic pop;
    logic [PTR_W-1:0] scan_index;

    assign full    = (occupancy_count == CNT_W'(DEPTH));
    assign empty   = (occupancy_count == '0);
    assign accept  = bus.request_valid && !full;
    assign enqueue = accept && !(DISCARD_ZERO && (bus.request_address == '0));
    assign pop     = !empty && !bus.write_inhibit;

    assign bus.request_ready                 = !full;
    assign bus.general_register_write_enable = pop;
    assign bus.address_3                     = empty ? '0 : entry_address[read_ptr];
    assign bus.general_register_write_data   = empty ? '0 : entry_data[read_ptr];
    assign bus.occupancy                     = occupancy_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            read_ptr        <= '0;
            write_ptr       <= '0;
            occupancy_count <= '0;
            entry_valid     <= '0;
        end else begin
            if (enqueue) begin
                write_ptr              <= write_ptr + PTR_W'(1);
                entry_valid[write_ptr] <= 1'b1;
            end
            // A push never lands on the popped slot: push needs not-full, pop needs not-empty.
            if (pop) begin
                read_ptr              <= read_ptr + PTR_W'(1);
                entry_valid[read_ptr] <= 1'b0;
            end
            if (enqueue && !pop) begin
                occupancy_count <= occupancy_count + CNT_W'(1);
            end else if (!enqueue && pop) begin
                occupancy_count <= occupancy_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enqueue) begin
            entry_address[write_ptr] <= bus.request_address;
            entry_data[write_ptr]    <= bus.request_data;
        end
    end

    // Walk from the most recently written slot backwards so the youngest match wins.
    always_comb begin
        bus.lookup_hit  = 1'b0;
        bus.lookup_data = '0;
        scan_index      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_index = write_ptr - PTR_W'(i + 1);
            if (!bus.lookup_hit && entry_valid[scan_index] &&
                (entry_address[scan_index] == bus.lookup_address) &&
                !(DISCARD_ZERO && (bus.lookup_address == '0))) begin
                bus.lookup_hit  = 1'b1;
                bus.lookup_data = entry_data[scan_index];
            end
        end
    end
endmodule
